spectrum_frame_reader: RTL and testbench
========================================

Name: spectrum_frame_reader

Overview:
- Reader side of the spectrum capture RAMs, which the FFT capture controller fills with 12-bit signed real/imag bins.
- On a start pulse it reads one full frame of bins, FFT_LEN deep, from the re/im RAM read ports.
- It emits the bins as a framed valid/ready stream (sop/eop) carrying re, im and re²+im².
- It absorbs the fixed RAM read latency under downstream backpressure with a small skid FIFO, so no bin is lost or duplicated.

Parameters:
- FFT_LEN, 4096, number of bins per frame; power of two, ≥ 4.
- AW, 12, RAM address width; log2(FFT_LEN).
- DW, 12, signed bin data width.
- RAM_LAT, 2, cycles from ram_rden/ram_rdaddr to valid ram_re_q/ram_im_q.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to stream one frame.
- busy  out  1  high from accepted start until the final beat handshakes.
- done  out  1  one-cycle pulse, the cycle after the eop beat handshakes.
- ram_rden  out  1  RAM read enable; shared by re and im RAMs.
- ram_rdaddr  out  AW  RAM read address.
- ram_re_q  in  DW  signed real read data.
- ram_im_q  in  DW  signed imag read data.
- src_valid  out  1  stream beat valid.
- src_ready  in  1  downstream accepts beat.
- src_sop  out  1  beat is bin 0.
- src_eop  out  1  beat is bin FFT_LEN-1.
- src_re  out  DW  bin real part.
- src_im  out  DW  bin imag part.
- src_pwr  out  2*DW+1  unsigned re²+im².

Behaviour:
- Reset (async, sys_rst low): state IDLE; busy, done, ram_rden, src_valid, src_sop, src_eop are 0; ram_rdaddr, src_re, src_im, src_pwr are 0; FIFO empty; in-flight count 0.
- Reset asserted mid-frame aborts immediately; no partial-frame completion after release.
- State machine: IDLE → READ → DRAIN → IDLE.
  - IDLE: start=1 → READ; busy=1 next cycle; read address counter = 0.
  - READ: issue a read (ram_rden=1, ram_rdaddr=counter, counter+1) only when inflight + fifo_count < FIFO_DEPTH. FIFO_DEPTH = RAM_LAT+2.
  - READ → DRAIN: in the same cycle that address FFT_LEN-1 is issued.
  - DRAIN: no reads. When the eop beat handshakes → IDLE; busy=0; done=1 for one cycle.
- start while busy=1 is ignored; no queuing.
- Read return path: a shift register of RAM_LAT valid bits tracks issued reads. Returning data is pushed into the FIFO together with the sop flag (address 0) and the eop flag (address FFT_LEN-1).
- Credit rule: the FIFO never overflows, by construction. Overflow is an assertion failure in verification.
- Output: src_* is the FIFO head; src_valid = FIFO not empty. A pop happens on src_valid & src_ready. Head fields are stable while src_valid=1 and src_ready=0.
- Simultaneous push and pop: allowed in the same cycle; the count is unchanged.
- Throughput: one beat per cycle when src_ready is held at 1.
- Minimum start-to-first-src_valid latency: 1 + RAM_LAT + 1 cycles (+1 with SPEC_PWR_EN).
- Beats leave strictly in address order 0..FFT_LEN-1: exactly one sop and one eop per frame.
- Arithmetic: re², im² are signed DW×DW products. src_pwr is their sum zero-extended to 2*DW+1; it never wraps. Example: re=-2048, im=-2048 gives 8388608.

Optional Feature:
- Macro SPEC_PWR_EN.
- Defined:
  - A register stage between RAM data and FIFO push computes src_pwr.
  - The in-flight tracker length becomes RAM_LAT+1.
  - FIFO_DEPTH becomes RAM_LAT+3.
- Undefined:
  - No multipliers are built.
  - src_pwr is tied to 0.
  - Latency and depth revert to the base values above.

Decomposition:
- Package spec_pkg holds:
  - the state enum (ST_IDLE, ST_READ, ST_DRAIN);
  - the FIFO_DEPTH derivation;
  - the pwr width constant;
  - the payload struct {sop, eop, re, im, pwr}.
- Sub-module spec_skid_fifo: a synchronous FIFO, parameterised by depth and payload width, with count, full and empty outputs.
- The frame reader instantiates one spec_skid_fifo and contains the FSM, address counter and latency tracker.

Test Plan:
- FFT_LEN=16, RAM model with re=k and im=-k at address k, src_ready=1 → 16 consecutive beats with re 0..15; sop only on beat 0, eop only on beat 15; done pulses once; busy falls in the same cycle done rises.
- Same setup, src_ready random at 50% → identical ordered data, no gaps or duplicates. Held beats are stable while stalled; FIFO count ≤ FIFO_DEPTH on every cycle.
- src_ready=0 for 20 cycles after start → reads stop after FIFO_DEPTH issues. On release, all 16 bins arrive in order.
- start pulsed again at beat 5 → ignored; exactly 16 beats follow and there is one done pulse. A second start after done streams a fresh frame from bin 0.
- sys_rst low at beat 7 → all outputs return to reset values asynchronously. After release there are no stray beats; a new start streams from sop.
- SPEC_PWR_EN defined, bin re=-3 im=4 → src_pwr=25; bin re=-2048 im=-2048 → src_pwr=8388608. With the macro undefined → src_pwr=0 and first-valid latency is one cycle shorter.

Source files
------------

// File: rtl/spec_pkg.sv
// Shared types and derived constants for spectrum_frame_reader.
// The bin width DW lives here because the FIFO payload struct is sized by it.
// SPEC_PWR_EN (optional): selects the extra power-computation stage, which deepens the FIFO.
package spec_pkg;

    localparam int unsigned DW    = 12;
    localparam int unsigned PWR_W = 2 * DW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic                 sop;
        logic                 eop;
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic [PWR_W-1:0]     pwr;
    } payload_t;

    localparam int unsigned PAYLOAD_W = $bits(payload_t);

    // Credit pool: every read that can be in flight plus the skid slots.
    function automatic int unsigned fifo_depth(input int unsigned ram_lat, input bit pwr_stage);
        return ram_lat + 32'd2 + (pwr_stage ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/spectrum_frame_reader_if.sv
// Framed valid/ready bin stream: one beat carries re, im and re^2+im^2.
interface spectrum_frame_reader_if #(
    parameter int unsigned DW = 12
);
    logic                 valid;
    logic                 ready;
    logic                 sop;
    logic                 eop;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [2*DW:0]        pwr;

    modport master (output valid, sop, eop, re, im, pwr, input ready);
    modport slave  (input valid, sop, eop, re, im, pwr, output ready);
endinterface

// File: rtl/spec_skid_fifo.sv
// Small synchronous FIFO that absorbs RAM read latency under backpressure.
// The head reads as zero while empty so idle stream fields stay quiet.
module spec_skid_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake qualification; a push into a full FIFO is only legal alongside a pop.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        count    = count_q;
        pop_data = empty ? '0 : mem[rd_ptr_q];
    end

    // Storage array, no reset needed since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spectrum_frame_reader.sv
// Reads one frame of FFT bins from the capture RAMs and streams them out with sop/eop framing.
// Reads are credit-limited so the skid FIFO can never overflow under backpressure.
// SPEC_PWR_EN (optional): adds a register stage computing re^2+im^2; otherwise pwr is zero.
module spectrum_frame_reader
    import spec_pkg::*;
#(
    parameter int unsigned FFT_LEN = 4096,
    parameter int unsigned AW      = 12,
    parameter int unsigned RAM_LAT = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_rden,
    output logic [AW-1:0]        ram_rdaddr,
    input  logic signed [DW-1:0] ram_re_q,
    input  logic signed [DW-1:0] ram_im_q,
    spectrum_frame_reader_if.master src
);
`ifdef SPEC_PWR_EN
    localparam bit PWR_STAGE = 1'b1;
`else
    localparam bit PWR_STAGE = 1'b0;
`endif
    localparam int unsigned TRK_LEN    = RAM_LAT + (PWR_STAGE ? 1 : 0);
    localparam int unsigned FIFO_DEPTH = fifo_depth(RAM_LAT, PWR_STAGE);
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FFT_LEN - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          done_q, done_d;
    logic          issue;

    logic [TRK_LEN-1:0] trk_vld_q;
    logic [TRK_LEN-1:0] trk_sop_q;
    logic [TRK_LEN-1:0] trk_eop_q;
    logic [CW-1:0]      inflight;

    payload_t      push_data;
    payload_t      head;
    logic          fifo_push;
    logic          fifo_pop;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    // Reads still travelling through the RAM (and power stage) each hold one FIFO credit.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < TRK_LEN; i++) begin
            inflight = inflight + CW'(trk_vld_q[i]);
        end
        issue = (state_q == ST_READ) &&
                (({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH));
    end

    // Next state, address counter and completion pulse.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_pop && head.eop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, address and done registers.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    // Latency tracker: a valid bit plus frame flags ride alongside each issued read.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            trk_vld_q <= '0;
            trk_sop_q <= '0;
            trk_eop_q <= '0;
        end else begin
            trk_vld_q[0] <= issue;
            trk_sop_q[0] <= issue && (addr_q == '0);
            trk_eop_q[0] <= issue && (addr_q == LAST_ADDR);
            for (int i = 1; i < TRK_LEN; i++) begin
                trk_vld_q[i] <= trk_vld_q[i-1];
                trk_sop_q[i] <= trk_sop_q[i-1];
                trk_eop_q[i] <= trk_eop_q[i-1];
            end
        end
    end

`ifdef SPEC_PWR_EN
    logic signed [2*DW-1:0] re_sq;
    logic signed [2*DW-1:0] im_sq;
    logic signed [DW-1:0]   stage_re_q;
    logic signed [DW-1:0]   stage_im_q;
    logic [PWR_W-1:0]       stage_pwr_q;

    // Squares are non-negative, so the zero-extended sum cannot wrap.
    always_comb begin
        re_sq = $signed((2*DW)'(ram_re_q)) * $signed((2*DW)'(ram_re_q));
        im_sq = $signed((2*DW)'(ram_im_q)) * $signed((2*DW)'(ram_im_q));
    end

    // Power stage captures RAM data on the cycle it is valid.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            stage_re_q  <= '0;
            stage_im_q  <= '0;
            stage_pwr_q <= '0;
        end else if (trk_vld_q[RAM_LAT-1]) begin
            stage_re_q  <= ram_re_q;
            stage_im_q  <= ram_im_q;
            stage_pwr_q <= PWR_W'($unsigned(re_sq)) + PWR_W'($unsigned(im_sq));
        end
    end
`endif

    // Assemble the FIFO push from the tracker flags and returned data.
    always_comb begin
        push_data     = '0;
        fifo_push     = trk_vld_q[TRK_LEN-1];
        push_data.sop = trk_sop_q[TRK_LEN-1];
        push_data.eop = trk_eop_q[TRK_LEN-1];
`ifdef SPEC_PWR_EN
        push_data.re  = stage_re_q;
        push_data.im  = stage_im_q;
        push_data.pwr = stage_pwr_q;
`else
        push_data.re  = ram_re_q;
        push_data.im  = ram_im_q;
        push_data.pwr = '0;
`endif
    end

    spec_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_W)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Stream side is the FIFO head; RAM side is driven straight from the FSM.
    always_comb begin
        fifo_pop   = !fifo_empty && src.ready;
        src.valid  = !fifo_empty;
        src.sop    = head.sop;
        src.eop    = head.eop;
        src.re     = head.re;
        src.im     = head.im;
        src.pwr    = head.pwr;
        ram_rden   = issue;
        ram_rdaddr = addr_q;
        busy       = (state_q != ST_IDLE);
        done       = done_q;
    end

    a_no_overflow: assert property (@(posedge sys_clk) disable iff (!sys_rst)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_spectrum_frame_reader.sv
// Self-checking bench for spectrum_frame_reader with a 16-bin frame.
// Define SPEC_PWR_EN for both RTL and bench to exercise the power stage.
module tb_spectrum_frame_reader;
    import spec_pkg::*;

    localparam int unsigned FFT_LEN = 16;
    localparam int unsigned AW      = 4;
    localparam int unsigned RAM_LAT = 2;
`ifdef SPEC_PWR_EN
    localparam bit PWR_ON = 1'b1;
`else
    localparam bit PWR_ON = 1'b0;
`endif
    localparam int DEPTH = RAM_LAT + 2 + (PWR_ON ? 1 : 0);
    localparam int LAT   = 1 + RAM_LAT + 1 + (PWR_ON ? 1 : 0);

    logic                 sys_clk = 1'b0;
    logic                 sys_rst = 1'b0;
    logic                 start   = 1'b0;
    logic                 busy;
    logic                 done;
    logic                 ram_rden;
    logic [AW-1:0]        ram_rdaddr;
    logic signed [DW-1:0] ram_re_q;
    logic signed [DW-1:0] ram_im_q;

    spectrum_frame_reader_if #(.DW(DW)) src ();

    spectrum_frame_reader #(
        .FFT_LEN (FFT_LEN),
        .AW      (AW),
        .RAM_LAT (RAM_LAT)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .ram_rden   (ram_rden),
        .ram_rdaddr (ram_rdaddr),
        .ram_re_q   (ram_re_q),
        .ram_im_q   (ram_im_q),
        .src        (src)
    );

    always #5 sys_clk = ~sys_clk;

    // RAM model: contents in arrays, two-cycle read pipeline.
    logic signed [DW-1:0] mem_re [FFT_LEN];
    logic signed [DW-1:0] mem_im [FFT_LEN];
    logic [AW-1:0]        a1 = '0;
    logic [AW-1:0]        a2 = '0;
    initial forever begin
        @(posedge sys_clk);
        a1 <= ram_rdaddr;
        a2 <= a1;
    end
    assign ram_re_q = mem_re[a2];
    assign ram_im_q = mem_im[a2];

    // Downstream ready: 0 = always ready, 1 = random 50%, 2 = stalled.
    int rdy_mode = 0;
    initial forever begin
        @(posedge sys_clk);
        #1;
        case (rdy_mode)
            0:       src.ready = 1'b1;
            1:       src.ready = 1'($urandom_range(0, 1));
            default: src.ready = 1'b0;
        endcase
    end

    typedef struct {
        int     re;
        int     im;
        bit     sop;
        bit     eop;
        longint pwr;
        int     cyc;
    } beat_t;

    beat_t got_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc_cnt = 0;
    int    done_cnt = 0;
    int    rden_cnt = 0;
    int    stab_err = 0;
    int    depth_err = 0;
    int    db_err = 0;

    // Monitor: collects handshaked beats and tallies protocol violations.
    initial begin
        bit     prev_stall = 1'b0;
        bit     prev_busy = 1'b0;
        bit     prev_done = 1'b0;
        longint prev_key = 0;
        longint key;
        forever begin
            @(negedge sys_clk);
            cyc_cnt++;
            key = {src.sop, src.eop, 12'(src.re), 12'(src.im), 25'(src.pwr)};
            if (!sys_rst) begin
                prev_stall = 1'b0;
                prev_busy  = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (src.valid && src.ready) begin
                    got_q.push_back('{int'(src.re), int'(src.im), src.sop, src.eop,
                                      longint'(src.pwr), cyc_cnt});
                end
                if (prev_stall && (!src.valid || key != prev_key)) stab_err++;
                prev_stall = src.valid && !src.ready;
                prev_key   = key;
                if (done) begin
                    done_cnt++;
                    if (busy || !prev_busy || prev_done) db_err++;
                end
                if (ram_rden) rden_cnt++;
                if (int'(dut.u_fifo.count) > DEPTH) depth_err++;
                prev_busy = busy;
                prev_done = done;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge sys_clk);
        #1 start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int n = 0;
        while (done_cnt == base && n < 2000) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        if (done_cnt == base) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no done within 2000 cycles, got %0d pulses, expected 1", name, 0);
        end
    endtask

    task automatic wait_beats(input int cnt, input string name);
        int n = 0;
        while (got_q.size() < cnt && n < 2000) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        if (got_q.size() < cnt) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got %0d beats, expected %0d", name, got_q.size(), cnt);
        end
    endtask

    // Reference: bin k must carry mem[k], flags from its index, pwr from the squares.
    task automatic check_frame(input string name);
        check({name, " beat count"}, got_q.size(), FFT_LEN);
        for (int k = 0; k < FFT_LEN && k < got_q.size(); k++) begin
            longint re = mem_re[k];
            longint im = mem_im[k];
            check($sformatf("%s bin%0d re", name, k), got_q[k].re, re);
            check($sformatf("%s bin%0d im", name, k), got_q[k].im, im);
            check($sformatf("%s bin%0d sop/eop", name, k),
                  2 * got_q[k].sop + got_q[k].eop, 2 * (k == 0) + (k == FFT_LEN - 1));
            check($sformatf("%s bin%0d pwr", name, k), got_q[k].pwr,
                  PWR_ON ? re * re + im * im : 0);
        end
    endtask

    task automatic ramp_mem();
        for (int k = 0; k < FFT_LEN; k++) begin
            mem_re[k] = DW'(k);
            mem_im[k] = DW'(-k);
        end
    endtask

    typedef struct {
        int     re;
        int     im;
        longint pwr;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int   d0;
        int   lat;
        int   busy_n1;

        tbl[0] = '{-3, 4, PWR_ON ? 64'd25 : 64'd0};
        tbl[1] = '{-2048, -2048, PWR_ON ? 64'd8388608 : 64'd0};
        tbl[2] = '{2047, -2048, PWR_ON ? 64'd8384513 : 64'd0};
        tbl[3] = '{0, 0, 64'd0};
        tbl[4] = '{5, 12, PWR_ON ? 64'd169 : 64'd0};
        tbl[5] = '{-1, -1, PWR_ON ? 64'd2 : 64'd0};
        tbl[6] = '{100, -7, PWR_ON ? 64'd10049 : 64'd0};

        ramp_mem();
        src.ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset rden", ram_rden, 0);
        check("reset rdaddr", ram_rdaddr, 0);
        check("reset valid", src.valid, 0);
        check("reset sop/eop", {src.sop, src.eop}, 0);
        check("reset re/im/pwr", (src.re != 0) + (src.im != 0) + (src.pwr != 0), 0);
        sys_rst = 1'b1;

        // Full-rate frame: latency, ordering, back-to-back beats, single done.
        got_q.delete();
        d0 = done_cnt;
        pulse_start();
        lat = 0;
        busy_n1 = 0;
        do begin
            @(negedge sys_clk);
            #1;
            lat++;
            if (lat == 1) busy_n1 = busy;
        end while (!src.valid && lat < 50);
        check("busy after start", busy_n1, 1);
        check("first valid latency", lat, LAT);
        wait_done(d0, "t1 done");
        check_frame("t1");
        check("t1 back-to-back span", got_q.size() == FFT_LEN ?
              got_q[FFT_LEN-1].cyc - got_q[0].cyc : -1, FFT_LEN - 1);
        repeat (3) @(negedge sys_clk);
        #1;
        check("t1 done pulses", done_cnt - d0, 1);
        check("t1 idle busy", busy, 0);

        // Random data under random backpressure.
        for (int k = 0; k < FFT_LEN; k++) begin
            mem_re[k] = DW'($urandom);
            mem_im[k] = DW'($urandom);
        end
        rdy_mode = 1;
        got_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done(d0, "t2 done");
        check_frame("t2");

        // Stalled sink: reads stop once the credit pool is used up.
        ramp_mem();
        rdy_mode = 2;
        got_q.delete();
        d0 = done_cnt;
        rden_cnt = 0;
        pulse_start();
        repeat (20) @(negedge sys_clk);
        #1;
        check("t3 reads while stalled", rden_cnt, DEPTH);
        check("t3 beats while stalled", got_q.size(), 0);
        rdy_mode = 0;
        wait_done(d0, "t3 done");
        check_frame("t3");

        // Start while busy is ignored; a later start streams a fresh frame.
        rdy_mode = 1;
        got_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_beats(5, "t4 beat5");
        pulse_start();
        wait_done(d0, "t4 done");
        repeat (10) @(negedge sys_clk);
        #1;
        check("t4 done pulses", done_cnt - d0, 1);
        check("t4 idle busy", busy, 0);
        check_frame("t4");
        got_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done(d0, "t4b done");
        check_frame("t4b");

        // Asynchronous reset mid-frame.
        rdy_mode = 0;
        got_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_beats(7, "t5 beat7");
        #2 sys_rst = 1'b0;
        #1;
        check("t5 async busy", busy, 0);
        check("t5 async valid", src.valid, 0);
        check("t5 async rden", ram_rden, 0);
        check("t5 async rdaddr", ram_rdaddr, 0);
        check("t5 async fields", {src.sop, src.eop, 12'(src.re), 12'(src.im)}, 0);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        got_q.delete();
        repeat (20) @(negedge sys_clk);
        #1;
        check("t5 stray beats", got_q.size(), 0);
        check("t5 stray done", done_cnt - d0, 0);
        check("t5 idle busy", busy, 0);
        d0 = done_cnt;
        pulse_start();
        wait_done(d0, "t5 done");
        check_frame("t5");

        // Arithmetic vectors placed at the start of the frame.
        for (int i = 0; i < 7; i++) begin
            mem_re[i] = DW'(tbl[i].re);
            mem_im[i] = DW'(tbl[i].im);
        end
        got_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done(d0, "t6 done");
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            check($sformatf("vec%0d re", i), got_q[i].re, tbl[i].re);
            check($sformatf("vec%0d im", i), got_q[i].im, tbl[i].im);
            check($sformatf("vec%0d pwr", i), got_q[i].pwr, tbl[i].pwr);
        end
        check_frame("t6");

        check("held beat stability", stab_err, 0);
        check("fifo count bound", depth_err, 0);
        check("done/busy alignment", db_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
